uart_packet_tx: RTL and testbench
=================================

Name: uart_packet_tx

Overview:
- Transmits a fixed 8-byte packet over a single UART TX line: 8N1 framing, LSB first, byte 0 first.
- It is the transmit counterpart of the 8-byte packet receiver. The host loads eight parallel bytes and pulses a start strobe. The block serializes the bytes with a configurable idle gap between them and pulses a done flag when the last stop bit completes.
- It contains its own baud-rate counter and bit serializer.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- UART_BPS, 115200, baud rate. Bit period BPS_CNT = CLK_FREQ/UART_BPS, integer-truncated; 434 at the defaults.
- GAP_BITS, 1, idle (high) bit periods inserted between consecutive bytes. Legal range 0..15.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous reset, active-low.
- packet_start  input  1  single-cycle start strobe. Honoured only while packet_busy=0.
- tx_data0 .. tx_data7  input  8 each  packet bytes. tx_data0 is sent first.
- uart_txd  output  1  UART serial output. Idle level is high.
- packet_busy  output  1  high while a packet is in flight.
- packet_done  output  1  one-cycle pulse when the packet completes.

Behaviour:
- Clock and reset:
  - One clock, clk. Reset is asynchronous and active-low on rst_n; all state clears immediately on assertion.
  - Reset values: uart_txd=1, packet_busy=0, packet_done=0, state=IDLE, byte index=0, bit index=0, baud counter=0.
- Start acceptance:
  - packet_start sampled high in cycle T while in IDLE starts a packet.
  - All eight tx_dataN bytes are latched in cycle T. Later changes to tx_dataN have no effect on the packet in flight.
- States: IDLE -> START -> DATA -> STOP -> (GAP ->) START ... -> IDLE.
  - IDLE: uart_txd=1, packet_busy=0.
  - START: uart_txd=0 for BPS_CNT cycles. The first start bit drives from cycle T+1, and packet_busy=1 from T+1.
  - DATA: 8 bits, LSB first, each held BPS_CNT cycles.
  - STOP: uart_txd=1 for BPS_CNT cycles.
  - After STOP of bytes 0..6: go to GAP if GAP_BITS>0, otherwise straight to START of the next byte.
  - GAP: uart_txd=1 for GAP_BITS*BPS_CNT cycles, then START of the next byte.
  - After STOP of byte 7: go to IDLE. No trailing gap is inserted.
- Baud counter:
  - Counts 0..BPS_CNT-1 and resets to 0 on every state/bit transition.
  - Each bit is exactly BPS_CNT clocks; there is no drift across the packet.
- Packet length: (80 + 7*GAP_BITS)*BPS_CNT cycles. packet_busy is high for exactly this many cycles, T+1 .. T+L.
- Completion:
  - In cycle T+L+1: packet_done=1 for exactly one cycle and packet_busy=0 in the same cycle.
  - uart_txd remains 1 throughout.
- Ignored strobes:
  - packet_start while packet_busy=1 is ignored. It is neither queued nor allowed to disturb the latched data.
  - packet_start in the packet_done cycle (T+L+1) is accepted; the next start bit begins at T+L+2.
- Reset mid-packet: uart_txd returns high asynchronously and the frame is truncated. No packet_done is generated. After release, the block waits in IDLE.
- Byte index wrap: the 3-bit index wraps 7->0 only on return to IDLE.
- Glitch-free output: uart_txd is driven from a register, never combinationally.

Test Plan:
- Basic packet, CLK_FREQ=1000, UART_BPS=100 (BPS_CNT=10), GAP_BITS=1, tx_data0..7=0x55,0xAA,0x00,0xFF,0x01,0x80,0x3C,0xA5, packet_start pulsed at T:
  - uart_txd=0 over T+1..T+10.
  - Bits decode LSB-first to the exact byte sequence with a 10-cycle high gap between bytes.
  - packet_busy high T+1..T+870; packet_done single pulse at T+870+1; packet_busy low that same cycle.
- Same setup with GAP_BITS=0: packet length 800 cycles; each stop bit is immediately followed by the next start bit; packet_done at T+801.
- Busy rejection: pulse packet_start at T+200 with all tx_dataN changed to 0x11 mid-packet -> transmitted bytes are unchanged, length is unchanged, and there is exactly one packet_done.
- Back-to-back: packet_start asserted in the packet_done cycle -> second packet's start bit begins one cycle later, and the second packet is fully correct.
- Async reset at T+355 (mid byte 3) -> uart_txd=1 and packet_busy=0 immediately, no packet_done. A fresh packet_start after release yields a complete, correct packet.
- Default parameters (BPS_CNT=434): a loopback into the 8-byte packet receiver returns all eight bytes in order, and the receiver's packet_done fires once.

Source files
------------

// File: rtl/uart_packet_tx.sv
// uart_packet_tx: sends eight latched bytes as 8N1 frames (LSB first, byte 0 first) with GAP_BITS idle bit periods between bytes.
// Ports: clk; rst_n async active-low; packet_start strobe accepted only in IDLE; tx_data0..7 packet bytes;
//        uart_txd registered serial line (idle high); packet_busy high while in flight; packet_done one-cycle completion pulse.
module uart_packet_tx #(
  parameter int CLK_FREQ = 50000000,
  parameter int UART_BPS = 115200,
  parameter int GAP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       packet_start,
  input  logic [7:0] tx_data0,
  input  logic [7:0] tx_data1,
  input  logic [7:0] tx_data2,
  input  logic [7:0] tx_data3,
  input  logic [7:0] tx_data4,
  input  logic [7:0] tx_data5,
  input  logic [7:0] tx_data6,
  input  logic [7:0] tx_data7,
  output logic       uart_txd,
  output logic       packet_busy,
  output logic       packet_done
);
  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int CW = $clog2(BPS_CNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BPS_CNT - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP_BITS > 0 ? GAP_BITS - 1 : 0);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;
  state_t r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0] r_bit, w_bit_nxt, r_byte, w_byte_nxt;
  logic [3:0] r_gap, w_gap_nxt;
  logic [63:0] r_data, w_data_nxt;
  logic r_txd, w_txd_nxt, r_done, w_done_nxt, w_end;
  assign w_end = r_cnt == CNT_LAST;
  assign uart_txd = r_txd;
  assign packet_busy = r_state != IDLE;
  assign packet_done = r_done;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_bit <= '0;
      r_byte <= '0;
      r_gap <= '0;
      r_data <= '0;
      r_txd <= 1'b1;
      r_done <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt <= w_cnt_nxt;
      r_bit <= w_bit_nxt;
      r_byte <= w_byte_nxt;
      r_gap <= w_gap_nxt;
      r_data <= w_data_nxt;
      r_txd <= w_txd_nxt;
      r_done <= w_done_nxt;
    end
  end
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt = w_end ? '0 : r_cnt + 1'b1;
    w_bit_nxt = r_bit;
    w_byte_nxt = r_byte;
    w_gap_nxt = r_gap;
    w_done_nxt = 1'b0;
    w_data_nxt = r_data;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (packet_start) begin
          w_state_nxt = START;
          w_byte_nxt = '0;
          w_data_nxt = {tx_data7, tx_data6, tx_data5, tx_data4, tx_data3, tx_data2, tx_data1, tx_data0};
        end
      end
      START: if (w_end) begin
        w_state_nxt = DATA;
        w_bit_nxt = '0;
      end
      DATA: if (w_end) begin
        w_state_nxt = r_bit == 3'd7 ? STOP : DATA;
        w_bit_nxt = r_bit + 1'b1;
      end
      STOP: if (w_end) begin
        w_state_nxt = r_byte == 3'd7 ? IDLE : (GAP_BITS > 0 ? GAP : START);
        w_done_nxt = r_byte == 3'd7;
        w_byte_nxt = r_byte + 1'b1;
        w_gap_nxt = '0;
      end
      GAP: if (w_end) begin
        w_state_nxt = r_gap == GAP_LAST ? START : GAP;
        w_gap_nxt = r_gap + 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
    // Line level is chosen from the upcoming state so the output flop changes in step with the state.
    w_txd_nxt = w_state_nxt == START ? 1'b0 : w_state_nxt == DATA ? w_data_nxt[{w_byte_nxt, w_bit_nxt}] : 1'b1;
  end
endmodule

// File: tb/tb_uart_packet_tx.sv
// tb_uart_packet_tx: bit-list model plus per-cycle compare for three uart_packet_tx configurations.
module tb_uart_packet_tx;
  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] st, txd, busy, done;
  logic [7:0] td [8];
  logic [2:0] q0 [$], q1 [$], q2 [$];
  logic [7:0] rxq [$];
  logic [7:0] rb;
  int n = 0, nf = 0, cyc = 0, done2 = 0;
  always #5 clk = ~clk;

  uart_packet_tx #(.CLK_FREQ(1000), .UART_BPS(100), .GAP_BITS(1)) u0 (
    .clk(clk), .rst_n(rst_n), .packet_start(st[0]),
    .tx_data0(td[0]), .tx_data1(td[1]), .tx_data2(td[2]), .tx_data3(td[3]),
    .tx_data4(td[4]), .tx_data5(td[5]), .tx_data6(td[6]), .tx_data7(td[7]),
    .uart_txd(txd[0]), .packet_busy(busy[0]), .packet_done(done[0]));
  uart_packet_tx #(.CLK_FREQ(1000), .UART_BPS(100), .GAP_BITS(0)) u1 (
    .clk(clk), .rst_n(rst_n), .packet_start(st[1]),
    .tx_data0(td[0]), .tx_data1(td[1]), .tx_data2(td[2]), .tx_data3(td[3]),
    .tx_data4(td[4]), .tx_data5(td[5]), .tx_data6(td[6]), .tx_data7(td[7]),
    .uart_txd(txd[1]), .packet_busy(busy[1]), .packet_done(done[1]));
  uart_packet_tx u2 (
    .clk(clk), .rst_n(rst_n), .packet_start(st[2]),
    .tx_data0(td[0]), .tx_data1(td[1]), .tx_data2(td[2]), .tx_data3(td[3]),
    .tx_data4(td[4]), .tx_data5(td[5]), .tx_data6(td[6]), .tx_data7(td[7]),
    .uart_txd(txd[2]), .packet_busy(busy[2]), .packet_done(done[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n++;
    if (act !== exp) begin
      nf++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int k, input logic [2:0] v);
    case (k)
      0: q0.push_back(v);
      1: q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  task automatic pop(input int k, output logic [2:0] e);
    e = 3'b100;
    case (k)
      0: if (q0.size() > 0) e = q0.pop_front();
      1: if (q1.size() > 0) e = q1.pop_front();
      default: if (q2.size() > 0) e = q2.pop_front();
    endcase
  endtask

  // Expected line per cycle: frame bits (start, 8 data LSB first, stop, gap ones) each bps cycles, then the done cycle.
  task automatic plan(input int k);
    int bps, gap;
    logic bit_v;
    bps = k == 2 ? 434 : 10;
    gap = k == 1 ? 0 : 1;
    for (int i = 0; i < 8; i++)
      for (int b = 0; b < 10 + (i < 7 ? gap : 0); b++) begin
        bit_v = b == 0 ? 1'b0 : (b < 9 ? td[i][b-1] : 1'b1);
        repeat (bps) push(k, {bit_v, 2'b10});
      end
    push(k, 3'b101);
  endtask

  task automatic send(input int k);
    st[k] = 1'b1;
    @(posedge clk);
    #1 st[k] = 1'b0;
    plan(k);
    cyc = 0;
  endtask

  task automatic goto(input int k);
    while (cyc < k) begin
      @(negedge clk);
      cyc++;
    end
    #1;
  endtask

  task automatic setd(input logic [63:0] v);
    for (int i = 0; i < 8; i++) td[i] = v[i*8 +: 8];
  endtask

  always @(negedge clk) begin
    logic [2:0] e;
    for (int k = 0; k < 3; k++) begin
      pop(k, e);
      n++;
      if ({txd[k], busy[k], done[k]} !== e) begin
        nf++;
        $display("FAIL cycle inst%0d t=%0t: {txd,busy,done} got %b expected %b", k, $time, {txd[k], busy[k], done[k]}, e);
      end
    end
    if (done[2]) done2++;
  end

  always begin
    @(negedge txd[2]);
    repeat (217) @(posedge clk);
    for (int b = 0; b < 8; b++) begin
      repeat (434) @(posedge clk);
      #1 rb[b] = txd[2];
    end
    repeat (434) @(posedge clk);
    rxq.push_back(rb);
  end

  initial begin
    rst_n = 1'b0;
    st = '0;
    setd(64'hA5_3C_80_01_FF_00_AA_55);
    repeat (3) @(negedge clk);
    #1;
    chk("reset_txd", {29'd0, txd}, 32'h7);
    chk("reset_busy", {29'd0, busy}, 32'h0);
    chk("reset_done", {29'd0, done}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    send(0);
    chk("basic_len", q0.size(), 871);
    goto(1);   chk("b_start_first", txd[0], 0); chk("b_busy_first", busy[0], 1);
    goto(10);  chk("b_start_last", txd[0], 0);
    goto(11);  chk("b_b0_bit0", txd[0], 1);
    goto(21);  chk("b_b0_bit1", txd[0], 0);
    goto(110); chk("b_gap_end", txd[0], 1);
    goto(111); chk("b_b1_start", txd[0], 0);
    goto(121); chk("b_b1_bit0", txd[0], 0);
    goto(870); chk("b_busy_last", busy[0], 1); chk("b_no_early_done", done[0], 0);
    goto(871); chk("b_done", done[0], 1); chk("b_busy_off", busy[0], 0); chk("b_txd_idle", txd[0], 1);
    goto(872); chk("b_done_one", done[0], 0);
    goto(875);
    send(1);
    chk("gap0_len", q1.size(), 801);
    goto(100); chk("g0_stop0", txd[1], 1);
    goto(101); chk("g0_start1", txd[1], 0);
    goto(800); chk("g0_busy_last", busy[1], 1);
    goto(801); chk("g0_done", done[1], 1);
    goto(805);
    send(0);
    goto(200);
    setd(64'h11_11_11_11_11_11_11_11);
    st[0] = 1'b1;
    @(posedge clk);
    #1 st[0] = 1'b0;
    goto(871); chk("rej_done", done[0], 1);
    goto(875); chk("rej_idle", busy[0], 0);
    setd(64'hA5_3C_80_01_FF_00_AA_55);
    send(0);
    goto(871); chk("b2b_first_done", done[0], 1);
    setd(64'h78_56_34_12_EF_BE_AD_DE);
    send(0);
    goto(1);   chk("b2b_start", txd[0], 0); chk("b2b_busy", busy[0], 1);
    goto(871); chk("b2b_second_done", done[0], 1);
    goto(875);
    setd(64'hA5_3C_80_01_FF_00_AA_55);
    send(0);
    goto(355); chk("rst_pre_busy", busy[0], 1);
    rst_n = 1'b0;
    q0.delete();
    #1;
    chk("rst_txd", txd[0], 1); chk("rst_busy", busy[0], 0); chk("rst_done", done[0], 0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    #1;
    send(0);
    goto(871); chk("post_rst_done", done[0], 1);
    goto(875);
    done2 = 0;
    send(2);
    chk("dflt_len", q2.size(), 37759);
    goto(37770);
    chk("lb_count", rxq.size(), 8);
    for (int i = 0; i < 8; i++) chk($sformatf("lb_byte%0d", i), rxq.size() > i ? {24'd0, rxq[i]} : 32'hFFFF, {24'd0, td[i]});
    chk("lb_done_once", done2, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n, nf);
    $finish;
  end
endmodule
